// File: rtl/mag_packet_serializer.sv
// Magnetometer packet serializer: frames a timestamped 3-axis packet as a byte stream over valid/ready.
// Optional checksum trailer byte when MAG_SER_CHECKSUM_EN is defined.
module mag_packet_serializer #(
  parameter int          TS_BYTES  = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [7:0]  PKT_ID    = 8'h4D
) (
  input  logic                     CLK_48MHZ,
  input  logic                     RESET,
  input  logic [8*TS_BYTES+47:0]   MDATA_PACKET,
  input  logic                     PACKET_STROBE,
  output logic [7:0]               TX_DATA,
  output logic                     TX_VALID,
  input  logic                     TX_READY,
  output logic                     BUSY,
  output logic [7:0]               DROP_COUNT
);

  localparam int PW = 8*TS_BYTES + 48;
  localparam int FN = 8 + TS_BYTES;
`ifdef MAG_SER_CHECKSUM_EN
  localparam int N  = FN + 1;
`else
  localparam int N  = FN;
`endif
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   active, active_n;
  logic [PW-1:0]   pend, pend_n;
  logic            pend_full, pend_full_n;
  logic [IW-1:0]   idx, idx_n;
  logic            busy, busy_n;
  logic [7:0]      drop, drop_n;
  logic [8*FN-1:0] frame;
  logic [7:0]      cur_byte;
  logic            xfer, last_xfer;
`ifdef MAG_SER_CHECKSUM_EN
  logic [7:0]      chk, chk_n;
`endif

  assign frame = {SYNC_BYTE, PKT_ID, active};

  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < FN; i++) begin
      if (idx == IW'(i)) cur_byte = frame[8*(FN-1-i) +: 8];
    end
`ifdef MAG_SER_CHECKSUM_EN
    if (idx == LAST_IDX) cur_byte = chk;
`endif
  end

  assign xfer      = (state == SEND) && TX_READY;
  assign last_xfer = xfer && (idx == LAST_IDX);

  always_comb begin
    state_n     = state;
    active_n    = active;
    pend_n      = pend;
    pend_full_n = pend_full;
    idx_n       = idx;
    drop_n      = drop;
`ifdef MAG_SER_CHECKSUM_EN
    chk_n       = chk;
`endif
    case (state)
      IDLE: begin
        if (PACKET_STROBE) begin
          active_n = MDATA_PACKET;
          idx_n    = '0;
          state_n  = SEND;
`ifdef MAG_SER_CHECKSUM_EN
          chk_n    = 8'h00;
`endif
        end
      end
      SEND: begin
        if (last_xfer) begin
          idx_n = '0;
`ifdef MAG_SER_CHECKSUM_EN
          chk_n = 8'h00;
`endif
          // A strobe landing on the last transfer always finds a slot: no drop.
          if (pend_full) begin
            active_n = pend;
            if (PACKET_STROBE) pend_n = MDATA_PACKET;
            else               pend_full_n = 1'b0;
          end else if (PACKET_STROBE) begin
            active_n = MDATA_PACKET;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_n = idx + 1'b1;
`ifdef MAG_SER_CHECKSUM_EN
            if (idx != '0) chk_n = chk + cur_byte;
`endif
          end
          if (PACKET_STROBE) begin
            if (!pend_full) begin
              pend_n      = MDATA_PACKET;
              pend_full_n = 1'b1;
            end else if (drop != 8'hFF) begin
              drop_n = drop + 8'h01;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == SEND) || pend_full_n;
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      state     <= IDLE;
      active    <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      drop      <= 8'h00;
`ifdef MAG_SER_CHECKSUM_EN
      chk       <= 8'h00;
`endif
    end else begin
      state     <= state_n;
      active    <= active_n;
      pend      <= pend_n;
      pend_full <= pend_full_n;
      idx       <= idx_n;
      busy      <= busy_n;
      drop      <= drop_n;
`ifdef MAG_SER_CHECKSUM_EN
      chk       <= chk_n;
`endif
    end
  end

  assign TX_VALID   = (state == SEND);
  assign TX_DATA    = TX_VALID ? cur_byte : 8'h00;
  assign BUSY       = busy;
  assign DROP_COUNT = drop;

endmodule

// File: tb/tb_mag_packet_serializer.sv
// Scoreboard bench for mag_packet_serializer: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_mag_packet_serializer;

  localparam int TSB = 4;
`ifdef MAG_SER_CHECKSUM_EN
  localparam int NB = 9 + TSB;
`else
  localparam int NB = 8 + TSB;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] pkt = '0;
  logic        stb = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic [7:0]  drop_count;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];
  bit   in_reset = 1'b1;
  bit   stalled  = 1'b0;
  logic [7:0] held = 8'h00;

  mag_packet_serializer #(.TS_BYTES(TSB)) dut (
    .CLK_48MHZ    (clk),
    .RESET        (rst),
    .MDATA_PACKET (pkt),
    .PACKET_STROBE(stb),
    .TX_DATA      (tx_data),
    .TX_VALID     (tx_valid),
    .TX_READY     (tx_ready),
    .BUSY         (busy),
    .DROP_COUNT   (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d required=0", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: pops one expected byte per transfer, and checks that stalled bytes stay put.
  always @(negedge clk) begin
    if (!in_reset) begin
      if (stalled) begin
        compared++;
        if (!(tx_valid && tx_data == held)) begin
          mismatched++;
          $display("FAIL stall_hold: got valid=%0b data=%02h, required valid=1 data=%02h", tx_valid, tx_data, held);
        end
      end
      if (tx_valid && tx_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_byte: got %02h, required no transfer", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            mismatched++;
            $display("FAIL tx_byte: got %02h, required %02h", tx_data, e);
          end
        end
      end
      stalled = tx_valid && !tx_ready;
      held    = tx_data;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  function automatic logic [79:0] mk(input logic [31:0] ts, input logic [15:0] x,
                                     input logic [15:0] y, input logic [15:0] z);
    return {ts, x, y, z};
  endfunction

  task automatic push_frame(input logic [79:0] p);
    logic [7:0] sum;
    logic [7:0] b;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h4D);
    sum = 8'h4D;
    for (int i = 0; i < 10; i++) begin
      b = p[8*(9-i) +: 8];
      exp_q.push_back(b);
      sum = sum + b;
    end
`ifdef MAG_SER_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic strobe(input logic [79:0] p, input bit expect_send);
    pkt = p;
    stb = 1'b1;
    if (expect_send) push_frame(p);
    tick();
    stb = 1'b0;
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [79:0] p1, p2, p3, p4;
    logic [7:0]  lit [12];
    logic [7:0]  lsum;
    logic [7:0]  d0;
    int          n;
    bit          rp [4];

    p1 = mk(32'h00010203, 16'h1122, 16'h3344, 16'h5566);
    p2 = mk(32'hDEADBEEF, 16'hCAFE, 16'h1234, 16'hABCD);
    p3 = mk(32'h80000001, 16'h0F0F, 16'hF0F0, 16'h7E81);
    p4 = mk(32'h11223344, 16'h0000, 16'hFFFF, 16'h0102);
    lit = '{8'hA5, 8'h4D, 8'h00, 8'h01, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rp  = '{1'b1, 1'b0, 1'b0, 1'b1};

    // reset state
    repeat (3) tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    rst = 1'b0;
    tick();
    in_reset = 1'b0;

    // single packet, hand-computed bytes
    tx_ready = 1'b1;
    lsum = 8'h00;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(lit[i]);
      if (i > 0) lsum = lsum + lit[i];
    end
`ifdef MAG_SER_CHECKSUM_EN
    exp_q.push_back(lsum);
`endif
    strobe(p1, 1'b0);
    check("single_first_valid", tx_valid, 1);
    check("single_first_data", tx_data, 8'hA5);
    repeat (NB) tick();
    check("single_end_valid", tx_valid, 0);
    check("single_end_busy", busy, 0);
    check("single_end_queue", exp_q.size(), 0);
    check("single_end_data", tx_data, 8'h00);

    // backpressure 1,0,0,1
    strobe(p1, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tx_ready = rp[n % 4];
      tick();
      n++;
    end
    check("bp_drain", exp_q.size(), 0);
    tx_ready = 1'b1;
    repeat (3) tick();
    check("bp_idle_valid", tx_valid, 0);

    // overflow: active, pending, dropped
    tx_ready = 1'b0;
    strobe(p2, 1'b1);
    tick();
    strobe(p3, 1'b1);
    tick();
    strobe(p4, 1'b0);
    tick();
    check("ovf_drop", drop_count, 1);
    check("ovf_busy", busy, 1);
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid && n < 100) begin
      tick();
      n++;
    end
    check("ovf_b2b_cycles", n, 2*NB);
    check("ovf_queue", exp_q.size(), 0);
    check("ovf_idle_busy", busy, 0);

    // strobe coincident with last-byte transfer
    strobe(p3, 1'b1);
    repeat (NB-1) tick();
    d0 = drop_count;
    strobe(p4, 1'b1);
    check("coin_valid", tx_valid, 1);
    check("coin_sync", tx_data, 8'hA5);
    check("coin_drop", drop_count, d0);
    drain("coin_drain", 100);

    // saturation
    tick();
    tx_ready = 1'b0;
    strobe(p2, 1'b1);
    strobe(p3, 1'b1);
    for (int i = 0; i < 298; i++) strobe(p4, 1'b0);
    check("sat_drop", drop_count, 8'hFF);
    tx_ready = 1'b1;
    drain("sat_drain", 100);
    tick();
    check("sat_idle_valid", tx_valid, 0);

    // reset mid-frame with pending full
    strobe(p2, 1'b1);
    strobe(p3, 1'b0);
    repeat (4) tick();
    check("mid_busy", busy, 1);
    in_reset = 1'b1;
    tx_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_data", tx_data, 8'h00);
    check("mid_sent_bytes", exp_q.size(), NB-5);
    exp_q.delete();
    rst = 1'b0;
    tick();
    in_reset = 1'b0;
    check("post_rst_valid", tx_valid, 0);

    tx_ready = 1'b1;
    strobe(p4, 1'b1);
    check("post_rst_sync", tx_data, 8'hA5);
    drain("post_rst_drain", 100);
    tick();
    check("post_rst_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
